// File: rtl/delay_line_pkg.sv
// Shared helpers for the runtime-programmable delay line: delay-field sizing
// and request clamping.
package delay_line_pkg;

    function automatic int delay_w(input int max);
        return $clog2(max + 1);
    endfunction

    function automatic int clamp_delay(input int req, input int max);
        return (req > max) ? max : req;
    endfunction

endpackage

// File: rtl/delay_tap_chain.sv
// Single-lane shift register with enable, synchronous clear and a selectable
// output tap (sel = 0 picks the stage nearest the input).
module delay_tap_chain
    import delay_line_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 16,
    localparam int SEL_W = delay_w(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [STAGES];
    logic [WIDTH-1:0] w_tap;

    // Clear wins over the shift so a sample arriving with clr never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else if (ena) begin
            r_stage[0] <= din;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    always_comb begin
        w_tap = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (sel == SEL_W'(i)) w_tap = r_stage[i];
        end
    end

    assign dout = w_tap;

endmodule

// File: rtl/var_delay_line.sv
// Multi-channel z^-n delay with runtime delay select, valid tracking, flush
// and a fill counter that reports when the current delay has been primed.
module var_delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int CHANNELS      = 4,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 1,
    localparam int DW           = delay_w(MAX_DELAY)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      flush,
    input  logic                      din_valid,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      dly_load,
    input  logic [DW-1:0]             dly_in,
    output logic [DW-1:0]             dly_cur,
    output logic                      dly_err,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic                      primed
);

    logic [DW-1:0]             r_dly_cur;
    logic                      r_dly_err;
    logic [DW-1:0]             r_fill_cnt;
    logic [DW-1:0]             w_sel;
    logic                      w_vld_clr;
    logic [CHANNELS*WIDTH-1:0] w_tap_data;
    logic                      w_tap_vld;

    assign w_vld_clr = flush | dly_load;
    assign w_sel     = r_dly_cur - DW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_cur <= DW'(DEFAULT_DELAY);
            r_dly_err <= 1'b0;
        end else begin
            r_dly_err <= 1'b0;
            if (dly_load) begin
                r_dly_cur <= DW'(clamp_delay(int'(32'(dly_in)), MAX_DELAY));
                r_dly_err <= (32'(dly_in) > 32'(MAX_DELAY));
            end
        end
    end

    // Counts enabled shifts since the last reset/flush/load, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
        end else if (w_vld_clr) begin
            r_fill_cnt <= '0;
        end else if (ena && (r_fill_cnt != {DW{1'b1}})) begin
            r_fill_cnt <= r_fill_cnt + DW'(1);
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_data
        delay_tap_chain #(
            .WIDTH  (WIDTH),
            .STAGES (MAX_DELAY)
        ) u_data (
            .clk   (clk),
            .rst_n (rst_n),
            .ena   (ena),
            .clr   (1'b0),
            .din   (din[ch*WIDTH +: WIDTH]),
            .sel   (w_sel),
            .dout  (w_tap_data[ch*WIDTH +: WIDTH])
        );
    end

    delay_tap_chain #(
        .WIDTH  (1),
        .STAGES (MAX_DELAY)
    ) u_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (w_vld_clr),
        .din   (din_valid),
        .sel   (w_sel),
        .dout  (w_tap_vld)
    );

    // A zero delay bypasses the chains entirely, so ena has no effect there.
    assign dout       = (r_dly_cur == '0) ? din       : w_tap_data;
    assign dout_valid = (r_dly_cur == '0) ? din_valid : w_tap_vld;
    assign dly_cur    = r_dly_cur;
    assign dly_err    = r_dly_err;
    assign primed     = (r_fill_cnt >= r_dly_cur);

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: reset, default delay, reload, stall,
// clamp, flush, pass-through and asynchronous reset mid-stream.
module tb_var_delay_line;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int DW       = 5;

    logic                      clk;
    logic                      rst_n;
    logic                      ena;
    logic                      flush;
    logic                      din_valid;
    logic [CHANNELS*WIDTH-1:0] din;
    logic                      dly_load;
    logic [DW-1:0]             dly_in;
    logic [DW-1:0]             dly_cur;
    logic                      dly_err;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      dout_valid;
    logic                      primed;

    int n_pass  = 0;
    int n_total = 0;

    var_delay_line #(
        .WIDTH         (WIDTH),
        .CHANNELS      (CHANNELS),
        .MAX_DELAY     (16),
        .DEFAULT_DELAY (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .flush      (flush),
        .din_valid  (din_valid),
        .din        (din),
        .dly_load   (dly_load),
        .dly_in     (dly_in),
        .dly_cur    (dly_cur),
        .dly_err    (dly_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .primed     (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Distinct value per channel so lane swaps are visible.
    function automatic logic [CHANNELS*WIDTH-1:0] mk(input int v);
        logic [CHANNELS*WIDTH-1:0] r;
        for (int c = 0; c < CHANNELS; c++) r[c*WIDTH +: WIDTH] = WIDTH'(v + c * 256);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; flush = 1'b0; din_valid = 1'b0;
        din = '0; dly_load = 1'b0; dly_in = '0;
        #12;
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_valid", 64'(dout_valid), 64'(0));
        chk("rst_dly_cur", 64'(dly_cur), 64'(1));
        chk("rst_dly_err", 64'(dly_err), 64'(0));
        chk("rst_primed", 64'(primed), 64'(0));
        rst_n = 1'b1;
        tick();

        // Default delay of 1
        ena = 1'b1; din_valid = 1'b1; din = mk(1);
        tick();
        chk("d1_first_dout", 64'(dout), 64'(mk(1)));
        chk("d1_first_valid", 64'(dout_valid), 64'(1));
        chk("d1_primed", 64'(primed), 64'(1));
        for (int v = 2; v <= 6; v++) begin
            din = mk(v);
            tick();
            chk("d1_stream", 64'(dout), 64'(mk(v)));
        end

        // Load delay 5
        dly_load = 1'b1; dly_in = 5'd5; din = mk(7);
        tick();
        dly_load = 1'b0;
        chk("d5_dly_cur", 64'(dly_cur), 64'(5));
        chk("d5_err", 64'(dly_err), 64'(0));
        chk("d5_clr_valid", 64'(dout_valid), 64'(0));
        chk("d5_clr_primed", 64'(primed), 64'(0));
        for (int k = 1; k <= 5; k++) begin
            din = mk(7 + k);
            tick();
            chk("d5_fill_valid", 64'(dout_valid), 64'(k == 5));
            chk("d5_fill_primed", 64'(primed), 64'(k == 5));
        end
        chk("d5_dout", 64'(dout), 64'(mk(8)));
        din = mk(13);
        tick();
        chk("d5_dout_next", 64'(dout), 64'(mk(9)));

        // Delay 4 with a 3-cycle stall
        dly_load = 1'b1; dly_in = 5'd4; din = mk(20);
        tick();
        dly_load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            din = mk(20 + k);
            tick();
        end
        chk("d4_pre_stall", 64'(dout), 64'(mk(22)));
        ena = 1'b0; din = mk(99);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_dout", 64'(dout), 64'(mk(22)));
            chk("stall_valid", 64'(dout_valid), 64'(1));
        end
        ena = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = mk(26 + k);
            tick();
            chk("resume_dout", 64'(dout), 64'(mk(23 + k)));
            chk("resume_valid", 64'(dout_valid), 64'(1));
        end

        // Over-range request clamps to 16
        dly_load = 1'b1; dly_in = 5'd19; din = mk(30);
        tick();
        dly_load = 1'b0;
        chk("clamp_dly_cur", 64'(dly_cur), 64'(16));
        chk("clamp_err_pulse", 64'(dly_err), 64'(1));
        for (int k = 1; k <= 16; k++) begin
            din = mk(30 + k);
            tick();
            if (k == 1) chk("clamp_err_drop", 64'(dly_err), 64'(0));
            chk("clamp_fill_valid", 64'(dout_valid), 64'(k == 16));
        end
        chk("clamp_dout", 64'(dout), 64'(mk(31)));

        // Delay 3, then flush while stalled with a valid sample present
        dly_load = 1'b1; dly_in = 5'd3; din = mk(50);
        tick();
        dly_load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            din = mk(50 + k);
            tick();
        end
        chk("d3_dout", 64'(dout), 64'(mk(51)));
        chk("d3_valid", 64'(dout_valid), 64'(1));
        flush = 1'b1; ena = 1'b0; din = mk(60);
        tick();
        flush = 1'b0; ena = 1'b1;
        chk("flush_valid", 64'(dout_valid), 64'(0));
        chk("flush_primed", 64'(primed), 64'(0));
        for (int k = 1; k <= 3; k++) begin
            din = mk(60 + k);
            tick();
            chk("flush_refill_valid", 64'(dout_valid), 64'(k == 3));
        end
        chk("flush_refill_dout", 64'(dout), 64'(mk(61)));

        // Delay 0: combinational pass-through
        dly_load = 1'b1; dly_in = 5'd0; din = mk(69);
        tick();
        dly_load = 1'b0;
        chk("d0_dly_cur", 64'(dly_cur), 64'(0));
        chk("d0_primed", 64'(primed), 64'(1));
        din = mk(70); din_valid = 1'b1;
        #1;
        chk("d0_pass_dout", 64'(dout), 64'(mk(70)));
        chk("d0_pass_valid", 64'(dout_valid), 64'(1));
        din = mk(71); din_valid = 1'b0; ena = 1'b0;
        #1;
        chk("d0_pass_dout2", 64'(dout), 64'(mk(71)));
        chk("d0_pass_valid2", 64'(dout_valid), 64'(0));

        // Delay 8, then asynchronous reset mid-stream
        ena = 1'b1; din_valid = 1'b1;
        dly_load = 1'b1; dly_in = 5'd8; din = mk(80);
        tick();
        dly_load = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            din = mk(80 + k);
            tick();
        end
        chk("d8_dout", 64'(dout), 64'(mk(81)));
        chk("d8_valid", 64'(dout_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", 64'(dout), 64'(0));
        chk("arst_valid", 64'(dout_valid), 64'(0));
        chk("arst_dly_cur", 64'(dly_cur), 64'(1));
        chk("arst_primed", 64'(primed), 64'(0));
        #2;
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
